// File: rtl/div_frec_pkg.sv
// Shared state encoding and default sizing for the
// programmable frequency divider controller.
package div_frec_pkg;

    localparam int DIV_WIDTH   = 9;
    localparam int DIV_DEFAULT = 499;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

endpackage

// File: rtl/div_frec_if.sv
// Divisor configuration handshake: valid/ready transfer
// plus a one-cycle error strobe for rejected values.
interface div_frec_if #(
    parameter int WIDTH = div_frec_pkg::DIV_WIDTH
);

    logic             Cfg_Valid;
    logic [WIDTH-1:0] Cfg_Div;
    logic             Cfg_Ready;
    logic             Cfg_Err;

    modport master (
        output Cfg_Valid,
        output Cfg_Div,
        input  Cfg_Ready,
        input  Cfg_Err
    );

    modport slave (
        input  Cfg_Valid,
        input  Cfg_Div,
        output Cfg_Ready,
        output Cfg_Err
    );

endinterface

// File: rtl/div_frec_core.sv
// Divide counter: counts 0..div, toggles divclk and
// strobes tick at each terminal count.
module div_frec_core
    import div_frec_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] div,
    output logic             term,
    output logic             divclk,
    output logic             tick
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             divclk_q, divclk_d;
    logic             tick_q, tick_d;

    assign term   = en && (q_q == div);
    assign divclk = divclk_q;
    assign tick   = tick_q;

    always_comb begin
        q_d      = q_q;
        divclk_d = divclk_q;
        tick_d   = 1'b0;
        // clear beats terminal count so a stop never ticks
        if (clr) begin
            q_d      = '0;
            divclk_d = 1'b0;
        end else if (term) begin
            q_d      = '0;
            divclk_d = ~divclk_q;
            tick_d   = 1'b1;
        end else if (en) begin
            q_d = q_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q      <= '0;
            divclk_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            q_q      <= q_d;
            divclk_q <= divclk_d;
            tick_q   <= tick_d;
        end
    end

endmodule

// File: rtl/div_frec_ctrl.sv
// Run/stop FSM and divisor front-end; divisor changes made
// while running wait for the next terminal count.
module div_frec_ctrl
    import div_frec_pkg::*;
#(
    parameter int WIDTH       = DIV_WIDTH,
    parameter int DEFAULT_DIV = DIV_DEFAULT
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Stop,
    div_frec_if.slave  cfg,
    output logic       DivCLK,
    output logic       Tick,
    output logic       Busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             xfer, ok, clr, term;

    assign xfer = cfg.Cfg_Valid && ready_q;
    assign ok   = xfer && (cfg.Cfg_Div != '0);
    assign clr  = Stop && busy_q;

    assign cfg.Cfg_Ready = ready_q;
    assign cfg.Cfg_Err   = err_q;
    assign Busy          = busy_q;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        pend_d  = pend_q;
        ready_d = ready_q;
        err_d   = xfer && (cfg.Cfg_Div == '0);
        case (state_q)
            IDLE: begin
                if (ok) div_d = cfg.Cfg_Div;
                if (Start && !Stop) state_d = RUN;
            end
            RUN: begin
                if (Stop) begin
                    state_d = IDLE;
                    if (ok) div_d = cfg.Cfg_Div;
                end else if (ok) begin
                    pend_d  = cfg.Cfg_Div;
                    ready_d = 1'b0;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (Stop || term) begin
                    div_d   = pend_q;
                    ready_d = 1'b1;
                    state_d = Stop ? IDLE : RUN;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            div_q   <= WIDTH'(DEFAULT_DIV);
            pend_q  <= '0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    div_frec_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (CLK),
        .rst_n  (Reset),
        .en     (busy_q),
        .clr    (clr),
        .div    (div_q),
        .term   (term),
        .divclk (DivCLK),
        .tick   (Tick)
    );

endmodule

// File: tb/tb_div_frec_ctrl.sv
// Bench for div_frec_ctrl: expected tick events are queued
// when stimulus starts a run and popped as ticks arrive.
module tb_div_frec_ctrl;
    import div_frec_pkg::*;

    localparam int W = DIV_WIDTH;

    typedef struct {
        int   cyc;
        logic clk;
    } exp_t;

    logic CLK   = 1'b0;
    logic Reset = 1'b0;
    logic Start = 1'b0;
    logic Stop  = 1'b0;
    logic DivCLK, Tick, Busy;

    div_frec_if #(.WIDTH(W)) cfg_if ();

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t exp_q[$];
    int   last_tick;
    logic last_clk;

    div_frec_ctrl #(
        .WIDTH       (W),
        .DEFAULT_DIV (DIV_DEFAULT)
    ) dut (
        .CLK    (CLK),
        .Reset  (Reset),
        .Start  (Start),
        .Stop   (Stop),
        .cfg    (cfg_if),
        .DivCLK (DivCLK),
        .Tick   (Tick),
        .Busy   (Busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time=%0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic start_run(output int t0);
        @(negedge CLK);
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        t0 = cyc;
    endtask

    task automatic stop_run();
        @(negedge CLK);
        Stop = 1'b1;
        @(negedge CLK);
        Stop = 1'b0;
    endtask

    task automatic wait_tick(input int budget, output int tc,
                             output logic c, output bit to);
        to = 1'b1;
        tc = -1;
        c  = 1'bx;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (Tick === 1'b1) begin
                tc = cyc;
                c  = DivCLK;
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        cfg_if.Cfg_Valid = 1'b0;
        cfg_if.Cfg_Div   = '0;
        Reset = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({DivCLK, Tick, cfg_if.Cfg_Ready,
             cfg_if.Cfg_Err, Busy} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 00100",
                     {DivCLK, Tick, cfg_if.Cfg_Ready,
                      cfg_if.Cfg_Err, Busy});
        end
        Reset = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_default_run();
        int t0, tc;
        logic c;
        bit to;
        exp_t e;
        start_run(t0);
        exp_q.push_back(exp_t'{t0 + 500, 1'b1});
        exp_q.push_back(exp_t'{t0 + 1000, 1'b0});
        checks++;
        if (Busy !== 1'b1) begin
            errors++;
            $display("FAIL default_busy: got %b, required 1", Busy);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_tick(600, tc, c, to);
            checks++;
            if (to || tc != e.cyc || c !== e.clk) begin
                errors++;
                $display("FAIL default_tick: cyc=%0d clk=%b to=%0d, required cyc=%0d clk=%b",
                         tc, c, to, e.cyc, e.clk);
            end
        end
        stop_run();
        checks++;
        if ({Busy, DivCLK} !== 2'b00) begin
            errors++;
            $display("FAIL default_stop: busy/clk=%b, required 00",
                     {Busy, DivCLK});
        end
    endtask

    task automatic test_idle_cfg();
        int t0, drop;
        exp_t e;
        @(negedge CLK);
        cfg_if.Cfg_Valid = 1'b1;
        cfg_if.Cfg_Div   = W'(3);
        @(negedge CLK);
        cfg_if.Cfg_Valid = 1'b0;
        checks++;
        if ({cfg_if.Cfg_Ready, cfg_if.Cfg_Err, Busy} !== 3'b100) begin
            errors++;
            $display("FAIL idle_cfg_accept: got %b, required 100",
                     {cfg_if.Cfg_Ready, cfg_if.Cfg_Err, Busy});
        end
        start_run(t0);
        for (int k = 1; k <= 4; k++)
            exp_q.push_back(exp_t'{t0 + 4 * k, k[0]});
        drop = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            if (cfg_if.Cfg_Ready !== 1'b1) drop++;
            if (Tick === 1'b1) begin
                if (exp_q.size() == 0) begin
                    e = exp_t'{-1, 1'bx};
                end else begin
                    e = exp_q.pop_front();
                end
                checks++;
                if (cyc != e.cyc || DivCLK !== e.clk) begin
                    errors++;
                    $display("FAIL idle_cfg_tick: cyc=%0d clk=%b, required cyc=%0d clk=%b",
                             cyc, DivCLK, e.cyc, e.clk);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL idle_cfg_missing: left=%0d, required 0",
                     exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (drop != 0) begin
            errors++;
            $display("FAIL idle_cfg_ready: low cycles=%0d, required 0",
                     drop);
        end
        last_tick = t0 + 16;
        last_clk  = 1'b0;
        @(negedge CLK);
        checks++;
        if (Tick !== 1'b0) begin
            errors++;
            $display("FAIL tick_width: got %b, required 0", Tick);
        end
    endtask

    task automatic test_pend_apply();
        int t, tc;
        logic c;
        bit to;
        exp_t e;
        t = last_tick;
        cfg_if.Cfg_Valid = 1'b1;
        cfg_if.Cfg_Div   = W'(1);
        @(negedge CLK);
        cfg_if.Cfg_Div = W'(5);
        checks++;
        if ({cfg_if.Cfg_Ready, Busy} !== 2'b01) begin
            errors++;
            $display("FAIL pend_ready_low: got %b, required 01",
                     {cfg_if.Cfg_Ready, Busy});
        end
        @(negedge CLK);
        cfg_if.Cfg_Valid = 1'b0;
        checks++;
        if (cfg_if.Cfg_Ready !== 1'b0) begin
            errors++;
            $display("FAIL pend_ready_hold: got %b, required 0",
                     cfg_if.Cfg_Ready);
        end
        exp_q.push_back(exp_t'{t + 4, 1'b1});
        exp_q.push_back(exp_t'{t + 6, 1'b0});
        exp_q.push_back(exp_t'{t + 8, 1'b1});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_tick(8, tc, c, to);
            checks++;
            if (to || tc != e.cyc || c !== e.clk) begin
                errors++;
                $display("FAIL pend_tick: cyc=%0d clk=%b to=%0d, required cyc=%0d clk=%b",
                         tc, c, to, e.cyc, e.clk);
            end
            if (e.cyc == t + 4) begin
                checks++;
                if (cfg_if.Cfg_Ready !== 1'b1) begin
                    errors++;
                    $display("FAIL pend_ready_back: got %b, required 1",
                             cfg_if.Cfg_Ready);
                end
            end
        end
    endtask

    task automatic test_zero_div();
        int ta, tc;
        logic ca, c;
        bit to;
        exp_t e;
        cfg_if.Cfg_Valid = 1'b1;
        cfg_if.Cfg_Div   = '0;
        @(negedge CLK);
        cfg_if.Cfg_Valid = 1'b0;
        checks++;
        if ({cfg_if.Cfg_Err, cfg_if.Cfg_Ready, Busy} !== 3'b111) begin
            errors++;
            $display("FAIL zero_err: err/rdy/busy=%b, required 111",
                     {cfg_if.Cfg_Err, cfg_if.Cfg_Ready, Busy});
        end
        @(negedge CLK);
        checks++;
        if (cfg_if.Cfg_Err !== 1'b0) begin
            errors++;
            $display("FAIL zero_err_pulse: got %b, required 0",
                     cfg_if.Cfg_Err);
        end
        wait_tick(8, ta, ca, to);
        exp_q.push_back(exp_t'{ta + 2, ~ca});
        e = exp_q.pop_front();
        wait_tick(8, tc, c, to);
        checks++;
        if (to || tc != e.cyc || c !== e.clk) begin
            errors++;
            $display("FAIL zero_div_kept: cyc=%0d clk=%b, required cyc=%0d clk=%b",
                     tc, c, e.cyc, e.clk);
        end
        stop_run();
    endtask

    task automatic test_stop_pend();
        int t0, tc;
        logic c;
        bit to;
        exp_t e;
        @(negedge CLK);
        Start = 1'b1;
        Stop  = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        Stop  = 1'b0;
        @(negedge CLK);
        checks++;
        if ({Busy, DivCLK} !== 2'b00) begin
            errors++;
            $display("FAIL start_stop_idle: busy/clk=%b, required 00",
                     {Busy, DivCLK});
        end
        start_run(t0);
        wait_tick(8, tc, c, to);
        cfg_if.Cfg_Valid = 1'b1;
        cfg_if.Cfg_Div   = W'(7);
        @(negedge CLK);
        cfg_if.Cfg_Valid = 1'b0;
        Stop = 1'b1;
        checks++;
        if ({cfg_if.Cfg_Ready, DivCLK} !== 2'b01) begin
            errors++;
            $display("FAIL stop_pend_pre: rdy/clk=%b, required 01",
                     {cfg_if.Cfg_Ready, DivCLK});
        end
        @(negedge CLK);
        Stop = 1'b0;
        checks++;
        if ({Busy, DivCLK, Tick, cfg_if.Cfg_Ready} !== 4'b0001) begin
            errors++;
            $display("FAIL stop_pend_idle: busy/clk/tick/rdy=%b, required 0001",
                     {Busy, DivCLK, Tick, cfg_if.Cfg_Ready});
        end
        start_run(t0);
        exp_q.push_back(exp_t'{t0 + 8, 1'b1});
        exp_q.push_back(exp_t'{t0 + 16, 1'b0});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_tick(12, tc, c, to);
            checks++;
            if (to || tc != e.cyc || c !== e.clk) begin
                errors++;
                $display("FAIL stop_pend_tick: cyc=%0d clk=%b to=%0d, required cyc=%0d clk=%b",
                         tc, c, to, e.cyc, e.clk);
            end
        end
        stop_run();
    endtask

    task automatic test_stop_cfg();
        int t0, tc;
        logic c;
        bit to;
        exp_t e;
        start_run(t0);
        cfg_if.Cfg_Valid = 1'b1;
        cfg_if.Cfg_Div   = W'(2);
        Stop = 1'b1;
        @(negedge CLK);
        cfg_if.Cfg_Valid = 1'b0;
        Stop = 1'b0;
        checks++;
        if ({Busy, cfg_if.Cfg_Ready} !== 2'b01) begin
            errors++;
            $display("FAIL stop_cfg_idle: busy/rdy=%b, required 01",
                     {Busy, cfg_if.Cfg_Ready});
        end
        start_run(t0);
        exp_q.push_back(exp_t'{t0 + 3, 1'b1});
        exp_q.push_back(exp_t'{t0 + 6, 1'b0});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_tick(6, tc, c, to);
            checks++;
            if (to || tc != e.cyc || c !== e.clk) begin
                errors++;
                $display("FAIL stop_cfg_tick: cyc=%0d clk=%b to=%0d, required cyc=%0d clk=%b",
                         tc, c, to, e.cyc, e.clk);
            end
        end
        stop_run();
    endtask

    task automatic test_reset_mid();
        int t0, tc;
        logic c;
        bit to;
        exp_t e;
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        Reset = 1'b1;
        start_run(t0);
        exp_q.push_back(exp_t'{t0 + 500, 1'b1});
        e = exp_q.pop_front();
        wait_tick(600, tc, c, to);
        checks++;
        if (to || tc != e.cyc || c !== e.clk) begin
            errors++;
            $display("FAIL rst_first_tick: cyc=%0d clk=%b, required cyc=%0d clk=%b",
                     tc, c, e.cyc, e.clk);
        end
        repeat (198) @(negedge CLK);
        cfg_if.Cfg_Valid = 1'b1;
        cfg_if.Cfg_Div   = W'(5);
        @(negedge CLK);
        cfg_if.Cfg_Valid = 1'b0;
        #2;
        Reset = 1'b0;
        #1;
        checks++;
        if ({Busy, DivCLK, Tick, cfg_if.Cfg_Ready} !== 4'b0001) begin
            errors++;
            $display("FAIL rst_mid_async: busy/clk/tick/rdy=%b, required 0001",
                     {Busy, DivCLK, Tick, cfg_if.Cfg_Ready});
        end
        @(negedge CLK);
        Reset = 1'b1;
        start_run(t0);
        exp_q.push_back(exp_t'{t0 + 500, 1'b1});
        e = exp_q.pop_front();
        wait_tick(600, tc, c, to);
        checks++;
        if (to || tc != e.cyc || c !== e.clk) begin
            errors++;
            $display("FAIL rst_default_div: cyc=%0d clk=%b, required cyc=%0d clk=%b",
                     tc, c, e.cyc, e.clk);
        end
        stop_run();
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_idle_cfg();
        test_pend_apply();
        test_zero_div();
        test_stop_pend();
        test_stop_cfg();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
